// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with a one-entry holding register and optional parity
module uart_tx #(
  parameter int DATA_WIDTH    = 8,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  TX_BR_TICKS,
  input  logic                  PARITY_EN,
  input  logic                  PARITY_MODE,
  input  logic                  TX_START,
  input  logic [DATA_WIDTH-1:0] TX_DATA_IN,
  output logic                  TX_READY,
  output logic                  TX,
  output logic                  TX_BUSY,
  output logic                  TX_DONE
);

  localparam int CNT_W = $clog2(TICKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_next;
  logic [CNT_W-1:0]      tick_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  frame_par_en;
  logic                  parity_bit;
  logic                  bit_end;
  logic                  load_frame;

  assign TX_READY   = ~hold_full;
  assign shift_next = shift_reg >> 1;
  assign bit_end    = (state != IDLE) && TX_BR_TICKS && (tick_cnt == CNT_LAST);
  // A waiting byte starts either from idle or straight out of the stop bit, with no idle gap
  assign load_frame = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      hold_data    <= '0;
      hold_full    <= 1'b0;
      shift_reg    <= '0;
      tick_cnt     <= '0;
      bit_idx      <= '0;
      frame_par_en <= 1'b0;
      parity_bit   <= 1'b0;
      TX           <= 1'b1;
      TX_BUSY      <= 1'b0;
      TX_DONE      <= 1'b0;
    end else begin
      TX_DONE <= 1'b0;

      if (TX_START && !hold_full) begin
        hold_data <= TX_DATA_IN;
        hold_full <= 1'b1;
      end

      if (TX_BR_TICKS && (state != IDLE))
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;

      if (bit_end) begin
        case (state)
          START: begin
            state <= DATA;
            TX    <= shift_reg[0];
          end
          DATA: begin
            if (bit_idx == IDX_LAST) begin
              if (frame_par_en) begin
                state <= PARITY;
                TX    <= parity_bit;
              end else begin
                state <= STOP;
                TX    <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + 1'b1;
              shift_reg <= shift_next;
              TX        <= shift_next[0];
            end
          end
          PARITY: begin
            state <= STOP;
            TX    <= 1'b1;
          end
          STOP: begin
            TX_DONE <= 1'b1;
            state   <= IDLE;
            TX      <= 1'b1;
            TX_BUSY <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end

      // Parity is resolved at load so later PARITY_* changes cannot touch this frame
      if (load_frame) begin
        shift_reg    <= hold_data;
        hold_full    <= 1'b0;
        frame_par_en <= PARITY_EN;
        parity_bit   <= (^hold_data) ^ PARITY_MODE;
        tick_cnt     <= '0;
        bit_idx      <= '0;
        state        <= START;
        TX           <= 1'b0;
        TX_BUSY      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized and directed bench for uart_tx against a queue-based line model
module tb_uart_tx;

  localparam int TPB = 16;
  typedef bit bitq_t[$];

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       TX_BR_TICKS = 1'b0;
  logic       PARITY_EN = 1'b0;
  logic       PARITY_MODE = 1'b0;
  logic       TX_START = 1'b0;
  logic [7:0] TX_DATA_IN = 8'h00;
  logic       TX_READY, TX, TX_BUSY, TX_DONE;

  int n_checks = 0;
  int n_fails  = 0;
  int tick_period = 1;

  uart_tx #(.DATA_WIDTH(8), .TICKS_PER_BIT(TPB)) dut (
    .CLK(CLK), .RESET(RESET), .TX_BR_TICKS(TX_BR_TICKS),
    .PARITY_EN(PARITY_EN), .PARITY_MODE(PARITY_MODE),
    .TX_START(TX_START), .TX_DATA_IN(TX_DATA_IN),
    .TX_READY(TX_READY), .TX(TX), .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Serial image of one frame: start, data LSB first, optional parity, stop
  function automatic bitq_t frame_bits(input logic [7:0] d, input bit pe, input bit pm);
    bitq_t q;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    if (pe) q.push_back((($countones(d) % 2) == 1) ^ pm);
    q.push_back(1'b1);
    return q;
  endfunction

  initial begin : tick_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge CLK);
      if (tick_period == 0) TX_BR_TICKS = 1'b0;
      else begin
        ph = (ph + 1) % tick_period;
        TX_BR_TICKS = (ph == 0);
      end
    end
  end

  // Line model: bits still owed to the line, each lasting TPB ticks, plus a one-deep waiting byte
  bitq_t      m_line;
  int         m_ticks = 0;
  bit         m_hold_v = 1'b0;
  logic [7:0] m_hold_d = 8'h00;
  bit         m_done = 1'b0;
  bit         m_idle, m_fin, m_acc;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_line.delete();
      m_ticks  = 0;
      m_hold_v = 1'b0;
      m_done   = 1'b0;
    end else begin
      m_acc  = TX_START && !m_hold_v;
      m_idle = (m_line.size() == 0);
      m_fin  = 1'b0;
      if (!m_idle && TX_BR_TICKS) begin
        m_ticks++;
        if (m_ticks == TPB) begin
          m_ticks = 0;
          void'(m_line.pop_front());
          m_fin = (m_line.size() == 0);
        end
      end
      m_done = m_fin;
      if (m_hold_v && (m_idle || m_fin)) begin
        m_line   = frame_bits(m_hold_d, PARITY_EN, PARITY_MODE);
        m_ticks  = 0;
        m_hold_v = 1'b0;
      end
      if (m_acc) begin
        m_hold_v = 1'b1;
        m_hold_d = TX_DATA_IN;
      end
    end
  end

  always @(negedge CLK) begin
    check("model", {28'd0, TX, TX_BUSY, TX_READY, TX_DONE},
          {28'd0, (m_line.size() == 0) ? 1'b1 : m_line[0], m_line.size() != 0, !m_hold_v, m_done});
  end

  task automatic send(input logic [7:0] d);
    @(negedge CLK);
    TX_START   = 1'b1;
    TX_DATA_IN = d;
    @(negedge CLK);
    TX_START   = 1'b0;
  endtask

  // Called right after send(); samples every bit mid-way at one tick per cycle, with up to two writes
  task automatic play(input string tag, input bitq_t bits, input int wcyc, input logic [7:0] wdat,
                      input int wcyc2, input logic [7:0] wdat2, input int ndone);
    int dones;
    int n;
    dones = 0;
    n = bits.size() * TPB;
    @(negedge CLK);
    check({tag, "_fall"}, TX, 1'b0);
    for (int c = 0; c < n; c++) begin
      if (c == wcyc || c == wcyc2) begin
        TX_START   = 1'b1;
        TX_DATA_IN = (c == wcyc) ? wdat : wdat2;
      end else begin
        TX_START = 1'b0;
      end
      if (wcyc >= 0 && (c == wcyc + 1 || c == wcyc2 + 1)) check({tag, "_ready"}, TX_READY, 1'b0);
      if (c % TPB == TPB / 2) check({tag, "_bit"}, TX, bits[c / TPB]);
      dones += TX_DONE;
      @(negedge CLK);
    end
    TX_START = 1'b0;
    dones += TX_DONE;
    check({tag, "_ndone"}, dones, ndone);
    check({tag, "_end"}, {TX, TX_BUSY, TX_READY}, 3'b101);
    @(negedge CLK);
    check({tag, "_done_1cyc"}, TX_DONE, 1'b0);
  endtask

  initial begin : main
    bitq_t exp;
    int    k;
    int    chg;
    int    dones;
    logic  last_tx;

    repeat (3) @(negedge CLK);
    check("rst_state", {TX, TX_BUSY, TX_READY, TX_DONE}, 4'b1010);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);
    check("no_spont_start", {TX, TX_BUSY}, 2'b10);

    exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    send(8'hA5);
    play("a5", exp, -1, 8'h00, -1, 8'h00, 1);

    PARITY_EN = 1'b1;
    PARITY_MODE = 1'b0;
    exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    send(8'hA5);
    play("a5_even", exp, -1, 8'h00, -1, 8'h00, 1);
    PARITY_MODE = 1'b1;
    exp = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
    send(8'hA5);
    play("a5_odd", exp, -1, 8'h00, -1, 8'h00, 1);
    PARITY_EN = 1'b0;
    PARITY_MODE = 1'b0;

    exp = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    send(8'h55);
    play("b2b", exp, 40, 8'h0F, 60, 8'hFF, 2);

    tick_period = 4;
    send(8'hA5);
    k = 0;
    while (TX !== 1'b0 && k < 50) begin @(negedge CLK); k++; end
    check("p4_fall", TX, 1'b0);
    k = 0;
    while (TX === 1'b0 && k < 200) begin @(negedge CLK); k++; end
    k = 0;
    while (TX === 1'b1 && k < 200) begin @(negedge CLK); k++; end
    check("p4_bit_len", k, 64);
    repeat (20) @(negedge CLK);
    tick_period = 0;
    last_tx = TX;
    chg = 0;
    repeat (100) begin
      @(negedge CLK);
      if (TX !== last_tx) chg++;
    end
    check("freeze_tx", chg, 0);
    check("freeze_busy", TX_BUSY, 1'b1);
    tick_period = 1;
    k = 0;
    while (TX_BUSY !== 1'b0 && k < 400) begin @(negedge CLK); k++; end
    check("p4_drain", TX_BUSY, 1'b0);

    send(8'hA5);
    repeat (10) @(negedge CLK);
    send(8'h3C);
    repeat (61) @(negedge CLK);
    check("pre_rst_ready", TX_READY, 1'b0);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1 check("rst_mid_frame", {TX, TX_READY, TX_BUSY, TX_DONE}, 4'b1100);
    dones = 0;
    repeat (3) begin @(negedge CLK); dones += TX_DONE; end
    RESET = 1'b0;
    k = 0;
    repeat (400) begin
      @(negedge CLK);
      dones += TX_DONE;
      if (TX_BUSY !== 1'b0 || TX !== 1'b1) k++;
    end
    check("rst_no_done", dones, 0);
    check("rst_discard", k, 0);

    for (int p = 1; p <= 3; p++) begin
      tick_period = p;
      for (int c = 0; c < 3000; c++) begin
        @(negedge CLK);
        TX_START   = ($urandom_range(0, 29) == 0);
        TX_DATA_IN = 8'($urandom);
        if ($urandom_range(0, 49) == 0) PARITY_EN = ~PARITY_EN;
        if ($urandom_range(0, 49) == 0) PARITY_MODE = ~PARITY_MODE;
      end
    end
    TX_START = 1'b0;
    tick_period = 1;
    k = 0;
    while ((TX_BUSY !== 1'b0 || TX_READY !== 1'b1) && k < 2000) begin @(negedge CLK); k++; end
    check("rand_drain", {TX_BUSY, TX_READY}, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
